// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider with glitch-free ratio change
//
// Divides clk by a run-time ratio N (2..2^WIDTH-1). Each period is N enabled
// cycles: floor(N/2) cycles with clk_out low, then the remainder with clk_out high.
// A newly loaded ratio is held pending and only swapped in at a period boundary,
// so clk_out never produces a runt pulse.
//
// Ports:
//   clk        - single clock, all state updates on its rising edge
//   rst        - synchronous active-high reset
//   en         - count enable; 0 freezes all counting state
//   div_in     - requested divide ratio N (0 and 1 are clamped to 2)
//   div_load   - one-cycle strobe that captures div_in
//   clk_out    - divided clock (registered)
//   tick       - one-cycle pulse on the last cycle of each period (registered)
//   count      - position within the current period, 0..N-1
//   div_active - ratio currently in use
//   load_pend  - a loaded ratio is waiting for the period boundary
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active,
  output logic             load_pend
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             load_pend_q, load_pend_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] div_clamped;
  logic             wrap;

  assign div_clamped = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;
  // Last cycle of the period being advanced past; count never exceeds N-1,
  // so with N <= 2^WIDTH-1 the increment below cannot overflow.
  assign wrap        = en && (count_q == div_active_q - WIDTH'(1));

  always_comb begin
    count_d      = count_q;
    div_active_d = div_active_q;
    pend_d       = pend_q;
    load_pend_d  = load_pend_q;

    if (wrap) begin
      count_d     = '0;
      load_pend_d = 1'b0;
      if (div_load) begin
        // A load landing on the boundary goes straight into the next period.
        div_active_d = div_clamped;
        pend_d       = div_clamped;
      end else if (load_pend_q) begin
        div_active_d = pend_q;
      end
    end else begin
      if (en) begin
        count_d = count_q + WIDTH'(1);
      end
      // Idle at the start of a period: nothing to protect, apply immediately.
      if (!en && (count_q == '0) && load_pend_q) begin
        div_active_d = pend_q;
        load_pend_d  = 1'b0;
      end
      if (div_load) begin
        pend_d      = div_clamped;
        load_pend_d = 1'b1;
      end
    end

    // Outputs are computed from next-state so the registers line up with count.
    clk_out_d = (count_d >= (div_active_d >> 1));
    tick_d    = en && (count_d == div_active_d - WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      div_active_q <= WIDTH'(DEFAULT_DIV);
      pend_q       <= WIDTH'(DEFAULT_DIV);
      load_pend_q  <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      load_pend_q  <= load_pend_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign count      = count_q;
  assign div_active = div_active_q;
  assign load_pend  = load_pend_q;

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - scoreboard bench for clk_div_n
module tb_clk_div_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_in = 8'd0;
  logic       div_load = 1'b0;
  logic       clk_out;
  logic       tick;
  logic [7:0] count;
  logic [7:0] div_active;
  logic       load_pend;

  clk_div_n #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_in     (div_in),
    .div_load   (div_load),
    .clk_out    (clk_out),
    .tick       (tick),
    .count      (count),
    .div_active (div_active),
    .load_pend  (load_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] c;
    logic       co;
    logic       t;
    logic [7:0] da;
    logic       lp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_id = 0;

  // Drive one cycle of stimulus and record the state expected after the next edge.
  task automatic step(input logic r, input logic e, input logic [7:0] din, input logic ld,
                      input logic [7:0] c, input logic co, input logic t,
                      input logic [7:0] da, input logic lp);
    exp_t x;
    @(negedge clk);
    rst      = r;
    en       = e;
    div_in   = din;
    div_load = ld;
    x.id = vec_id; x.c = c; x.co = co; x.t = t; x.da = da; x.lp = lp;
    exp_q.push_back(x);
    vec_id++;
  endtask

  // Monitor: outputs are presented every cycle; compare just after each edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        total++;
        if (count !== x.c || clk_out !== x.co || tick !== x.t ||
            div_active !== x.da || load_pend !== x.lp) begin
          bad++;
          $display("FAIL vec%0d cnt/clk/tick/div/pend got %0d/%0b/%0b/%0d/%0b want %0d/%0b/%0b/%0d/%0b",
                   x.id, count, clk_out, tick, div_active, load_pend,
                   x.c, x.co, x.t, x.da, x.lp);
        end
      end
    end
  end

  initial begin
    // Reset, then default ratio 2
    step(1,0,0,0, 0,0,0,2,0);
    step(0,1,0,0, 1,1,1,2,0);
    step(0,1,0,0, 0,0,0,2,0);
    step(0,1,0,0, 1,1,1,2,0);
    step(0,1,0,0, 0,0,0,2,0);

    // Load 5 while idle at count 0, applies next cycle, then run
    step(0,0,5,1, 0,0,0,2,1);
    step(0,0,0,0, 0,0,0,5,0);
    step(0,1,0,0, 1,0,0,5,0);
    step(0,1,0,0, 2,1,0,5,0);
    step(0,1,0,0, 3,1,0,5,0);
    step(0,1,0,0, 4,1,1,5,0);
    step(0,1,0,0, 0,0,0,5,0);

    // Switch to 4 at a boundary
    step(0,1,4,1, 1,0,0,5,1);
    step(0,1,0,0, 2,1,0,5,1);
    step(0,1,0,0, 3,1,0,5,1);
    step(0,1,0,0, 4,1,1,5,1);
    step(0,1,0,0, 0,0,0,4,0);
    // N=4, load 7 while count=1; period still completes in 4
    step(0,1,0,0, 1,0,0,4,0);
    step(0,1,7,1, 2,1,0,4,1);
    step(0,1,0,0, 3,1,1,4,1);
    step(0,1,0,0, 0,0,0,7,0);
    step(0,1,0,0, 1,0,0,7,0);
    step(0,1,0,0, 2,0,0,7,0);
    step(0,1,0,0, 3,1,0,7,0);
    step(0,1,0,0, 4,1,0,7,0);
    step(0,1,0,0, 5,1,0,7,0);
    step(0,1,0,0, 6,1,1,7,0);
    step(0,1,0,0, 0,0,0,7,0);

    // Load 0 then 1 -> clamped to 2 at boundary
    step(0,1,0,1, 1,0,0,7,1);
    step(0,1,1,1, 2,0,0,7,1);
    step(0,1,0,0, 3,1,0,7,1);
    step(0,1,0,0, 4,1,0,7,1);
    step(0,1,0,0, 5,1,0,7,1);
    step(0,1,0,0, 6,1,1,7,1);
    step(0,1,0,0, 0,0,0,2,0);
    step(0,1,0,0, 1,1,1,2,0);
    step(0,1,0,0, 0,0,0,2,0);

    // Load 6 then 9 before the boundary -> only 9 applies
    step(0,1,6,1, 1,1,1,2,1);
    step(0,0,9,1, 1,1,0,2,1);
    step(0,1,0,0, 0,0,0,9,0);
    step(0,1,0,0, 1,0,0,9,0);
    step(0,1,0,0, 2,0,0,9,0);
    step(0,1,0,0, 3,0,0,9,0);
    step(0,1,0,0, 4,1,0,9,0);
    step(0,1,0,0, 5,1,0,9,0);
    step(0,1,0,0, 6,1,0,9,0);
    step(0,1,0,0, 7,1,0,9,0);
    step(0,1,0,0, 8,1,1,9,0);
    // Load 3 on the wrap cycle -> applies to the very next period
    step(0,1,3,1, 0,0,0,3,0);
    step(0,1,0,0, 1,1,0,3,0);
    step(0,1,0,0, 2,1,1,3,0);
    step(0,1,0,0, 0,0,0,3,0);

    // N=8, freeze at count 3 for 5 cycles, then resume at 4
    step(0,1,8,1, 1,1,0,3,1);
    step(0,1,0,0, 2,1,1,3,1);
    step(0,1,0,0, 0,0,0,8,0);
    step(0,1,0,0, 1,0,0,8,0);
    step(0,1,0,0, 2,0,0,8,0);
    step(0,1,0,0, 3,0,0,8,0);
    for (int i = 0; i < 5; i++) step(0,0,0,0, 3,0,0,8,0);
    step(0,1,0,0, 4,1,0,8,0);
    step(0,1,0,0, 5,1,0,8,0);

    // Reset at count 5 wins over en and div_load
    step(1,1,9,1, 0,0,0,2,0);
    step(0,1,0,0, 1,1,1,2,0);
    step(0,1,0,0, 0,0,0,2,0);

    // Maximum ratio 255: L=127, tick at count 254
    step(0,0,255,1, 0,0,0,2,1);
    step(0,0,0,0,   0,0,0,255,0);
    for (int i = 1; i <= 254; i++)
      step(0,1,0,0, 8'(i), (i >= 127), (i == 254), 255, 0);
    // Freeze on the tick cycle: tick drops, count/clk_out hold
    step(0,0,0,0, 254,1,0,255,0);
    step(0,1,0,0, 0,0,0,255,0);
    step(0,1,0,0, 1,0,0,255,0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain queue left %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
